// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port, with its own level count.
// Define FIFO_ARB_PRIO0_EN to give requester 0 strict priority over the round-robin group.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int FIFO_SIZE = 16,
  parameter int NUM_REQ   = 4,
  parameter int PTR_WIDTH = $clog2(FIFO_SIZE)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  input  logic                     rd_fire,
  output logic [PTR_WIDTH:0]       level,
  output logic                     busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int LW    = PTR_WIDTH + 1;
  logic [IDX_W-1:0] rr_ptr, sel, cand;
  logic             hit, space, grant, dec, upd;
  assign space = level < LW'(FIFO_SIZE);
  assign dec   = rd_fire & (level != '0);
  // Search offsets high to low so the nearest requester at or after rr_ptr wins last.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (req[0]) begin
      hit = 1'b1;
      sel = '0;
    end
    upd = sel != '0;
`else
    upd = 1'b1;
`endif
    grant = res & space & hit;
    gnt   = grant ? NUM_REQ'(1) << sel : '0;
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      fifo_wr_en <= 1'b0;
      fifo_wdata <= '0;
      rr_ptr     <= '0;
      level      <= '0;
      busy       <= 1'b0;
    end else begin
      fifo_wr_en <= grant;
      fifo_wdata <= grant ? req_data[sel*WIDTH +: WIDTH] : '0;
      if (grant & upd) rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
      level      <= level + LW'(grant) - LW'(dec);
      busy       <= (|req) & (level == LW'(FIFO_SIZE));
    end
  end
endmodule
